// File: rtl/bus_mem_ctrl_if.sv
// Line-bus / word-memory signal bundle for bus_mem_ctrl.
// slave  : controller view (line-bus slave, word-memory master).
// master : environment view (line requester plus word memory).
//   bus_addr_i/bus_data_i/bus_we_i/bus_valid_i  line request
//   bus_data_o/bus_valid_o/bus_err_o/busy_o     line response and status
//   mem_addr_o/mem_wdata_o/mem_we_o/mem_req_o   word beat request
//   mem_ack_i/mem_rdata_i                       word beat completion
interface bus_mem_ctrl_if #(
  parameter int unsigned ADDR_W = 20
);
  logic [ADDR_W-1:4] bus_addr_i;
  logic [127:0]      bus_data_i;
  logic              bus_we_i;
  logic              bus_valid_i;
  logic [127:0]      bus_data_o;
  logic              bus_valid_o;
  logic              bus_err_o;
  logic              busy_o;
  logic [ADDR_W-1:2] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_we_o;
  logic              mem_req_o;
  logic              mem_ack_i;
  logic [31:0]       mem_rdata_i;

  modport slave (
    input  bus_addr_i, bus_data_i, bus_we_i, bus_valid_i, mem_ack_i, mem_rdata_i,
    output bus_data_o, bus_valid_o, bus_err_o, busy_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_req_o
  );

  modport master (
    output bus_addr_i, bus_data_i, bus_we_i, bus_valid_i, mem_ack_i, mem_rdata_i,
    input  bus_data_o, bus_valid_o, bus_err_o, busy_o,
           mem_addr_o, mem_wdata_o, mem_we_o, mem_req_o
  );
endinterface

// File: rtl/bus_mem_ctrl.sv
// Memory-side controller for the 128-bit cache line bus: splits each line
// read/write into four 32-bit req/ack beats, returns the assembled line with a
// one-cycle response pulse, and turns a hung beat into an error response.
//   clk_i  rising-edge clock
//   rst_i  synchronous active-high reset
//   bus    bus_mem_ctrl_if.slave (line request/response + word memory port)
module bus_mem_ctrl #(
  parameter int unsigned BUS_ADDRESS_WIDTH    = 20,
  parameter int unsigned BUS_DATA_WIDTH_SHIFT = 4,
  parameter int unsigned TIMEOUT_CYCLES       = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  bus_mem_ctrl_if.slave bus
);

  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned WD_W   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
  localparam bit WD_ON = (TIMEOUT_CYCLES != 0);

  // Only 128-bit lines are supported.
  if (BUS_DATA_WIDTH_SHIFT != 4) begin : g_bad_line_width
    $error("bus_mem_ctrl: BUS_DATA_WIDTH_SHIFT must be 4 (128-bit line)");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BEAT = 2'd1,
    ST_RESP = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  state_t                       state_q, state_d;
  logic [1:0]                   beat_q, beat_d;
  logic [WD_W-1:0]              wd_q, wd_d;
  logic [BUS_ADDRESS_WIDTH-1:4] addr_q, addr_d;
  logic [LINE_W-1:0]            wline_q, wline_d;
  logic                         we_q, we_d;
  logic [LINE_W-1:0]            line_q, line_d;
  logic [LINE_W-1:0]            rsp_data_q, rsp_data_d;
  logic                         rsp_valid_q, rsp_valid_d;
  logic                         rsp_err_q, rsp_err_d;
  logic                         busy_q, busy_d;
  logic                         req_q, req_d;
  logic                         mwe_q, mwe_d;

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      beat_q      <= '0;
      wd_q        <= '0;
      addr_q      <= '0;
      wline_q     <= '0;
      we_q        <= 1'b0;
      line_q      <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      req_q       <= 1'b0;
      mwe_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wd_q        <= wd_d;
      addr_q      <= addr_d;
      wline_q     <= wline_d;
      we_q        <= we_d;
      line_q      <= line_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      req_q       <= req_d;
      mwe_q       <= mwe_d;
    end
  end

  // Next-state and next-output logic; registered outputs are computed one
  // cycle ahead so they line up with the state they belong to.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wd_d        = wd_q;
    addr_d      = addr_q;
    wline_d     = wline_q;
    we_d        = we_q;
    line_d      = line_q;
    rsp_data_d  = rsp_data_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    busy_d      = busy_q;
    req_d       = req_q;
    mwe_d       = mwe_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.bus_valid_i) begin
          addr_d  = bus.bus_addr_i;
          wline_d = bus.bus_data_i;
          we_d    = bus.bus_we_i;
          beat_d  = 2'd0;
          wd_d    = '0;
          req_d   = 1'b1;
          mwe_d   = bus.bus_we_i;
          busy_d  = 1'b1;
          state_d = ST_BEAT;
        end
      end

      ST_BEAT: begin
        if (bus.mem_ack_i) begin
          wd_d = '0;
          if (!we_q) begin
            line_d[{beat_q, 5'd0} +: WORD_W] = bus.mem_rdata_i;
          end
          if (beat_q == 2'd3) begin
            req_d       = 1'b0;
            mwe_d       = 1'b0;
            rsp_valid_d = 1'b1;
            // Writes leave the previous read line on bus_data_o.
            if (!we_q) begin
              rsp_data_d = line_d;
            end
            state_d = ST_RESP;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else if (WD_ON && (wd_q == WD_LIMIT)) begin
          // Hung beat: abandon the line and report an error with zero data.
          req_d       = 1'b0;
          mwe_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
          state_d     = ST_RESP;
        end else if (WD_ON) begin
          wd_d = wd_q + WD_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_GAP;
      end

      ST_GAP: begin
        // Requester drops valid here; the request is not re-sampled.
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.bus_data_o  = rsp_data_q;
  assign bus.bus_valid_o = rsp_valid_q;
  assign bus.bus_err_o   = rsp_err_q;
  assign bus.busy_o      = busy_q;
  assign bus.mem_req_o   = req_q;
  assign bus.mem_we_o    = mwe_q;
  assign bus.mem_addr_o  = {addr_q, beat_q};
  assign bus.mem_wdata_o = wline_q[{beat_q, 5'd0} +: WORD_W];

endmodule

// File: tb/tb_bus_mem_ctrl.sv
// Scoreboard bench for bus_mem_ctrl: a word-memory model answers beats with
// programmable ack gaps, expected beats and line responses are queued when a
// request is issued and checked by independent memory-side and bus-side monitors.
module tb_bus_mem_ctrl;

  localparam int unsigned AW = 20;
  localparam int unsigned TO = 4;
  localparam int unsigned NEVER = 255;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bus_mem_ctrl_if #(.ADDR_W(AW)) bif ();

  bus_mem_ctrl #(
    .BUS_ADDRESS_WIDTH   (AW),
    .BUS_DATA_WIDTH_SHIFT(4),
    .TIMEOUT_CYCLES      (TO)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bif)
  );

  typedef struct {
    logic [17:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  typedef struct {
    logic         err;
    logic [127:0] data;
    int           lat;
  } resp_t;

  beat_t beat_q[$];
  resp_t resp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int gap[4];
  int mbeat = 0;
  int mwait = 0;
  bit spur_en = 1'b0;

  logic [31:0]  ref_mem[256];
  logic [31:0]  mem_store[256];
  logic [127:0] last_data = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] ref_line(input int line);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = ref_mem[(line * 4 + i) & 255];
    return r;
  endfunction

  // Word memory: acks each beat after gap[beat] idle cycles, random acks while idle.
  initial begin
    beat_t e;
    bif.mem_ack_i   = 1'b0;
    bif.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst || !bif.mem_req_o || mbeat >= 4) begin
        bif.mem_ack_i   = spur_en ? 1'($urandom % 2) : 1'b0;
        bif.mem_rdata_i = $urandom;
      end else if (mwait >= gap[mbeat]) begin
        bif.mem_ack_i = 1'b1;
        if (beat_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected actual=%h required=none", bif.mem_addr_o);
          bif.mem_rdata_i = $urandom;
        end else begin
          e = beat_q.pop_front();
          chk("beat_addr", 128'(bif.mem_addr_o), 128'(e.addr));
          chk("beat_we", 128'(bif.mem_we_o), 128'(e.we));
          if (e.we) chk("beat_wdata", 128'(bif.mem_wdata_o), 128'(e.wdata));
          if (bif.mem_we_o) begin
            mem_store[bif.mem_addr_o[9:2]] = bif.mem_wdata_o;
            bif.mem_rdata_i = $urandom;
          end else begin
            bif.mem_rdata_i = mem_store[bif.mem_addr_o[9:2]];
          end
        end
        mbeat++;
        mwait = 0;
      end else begin
        bif.mem_ack_i   = 1'b0;
        bif.mem_rdata_i = $urandom;
        mwait++;
      end
    end
  end

  // Response monitor: every bus_valid_o pulse is matched against the queue.
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bif.bus_valid_o) begin
        if (resp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL resp_unexpected actual=pulse required=none");
        end else begin
          e = resp_q.pop_front();
          chk("resp_err", 128'(bif.bus_err_o), 128'(e.err));
          chk("resp_data", bif.bus_data_o, e.data);
          chk("resp_latency", 128'(cyc - acc_cyc), 128'(e.lat));
        end
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (!bif.busy_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  // Waits for the response pulse; mem_req_o must stay high until then.
  task automatic wait_resp();
    bit seen = 1'b0;
    int drops = 0;
    for (int n = 0; n < 200; n++) begin
      if (bif.bus_valid_o) begin
        seen = 1'b1;
        break;
      end
      if (!bif.mem_req_o) drops++;
      @(negedge clk);
    end
    chk("resp_seen", 128'(seen), 128'(1));
    chk("req_held", 128'(drops), 128'(0));
  endtask

  task automatic do_tx(input int line, input logic we, input logic [127:0] wl,
                       input int g0, input int g1, input int g2, input int g3,
                       input bit scramble);
    int    fail_beat;
    int    lat;
    resp_t e;
    wait_idle();
    gap[0] = g0; gap[1] = g1; gap[2] = g2; gap[3] = g3;
    mbeat = 0;
    mwait = 0;
    fail_beat = 4;
    for (int i = 3; i >= 0; i--) if (gap[i] > int'(TO)) fail_beat = i;
    lat = 0;
    for (int i = 0; i < fail_beat; i++) lat += gap[i] + 1;
    if (fail_beat < 4) lat += int'(TO) + 1;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr  = 18'(line * 4 + i);
      b.we    = we;
      b.wdata = wl[i*32 +: 32];
      beat_q.push_back(b);
    end
    if (we) for (int i = 0; i < fail_beat; i++) ref_mem[(line * 4 + i) & 255] = wl[i*32 +: 32];
    if (fail_beat < 4) last_data = '0;
    else if (!we) last_data = ref_line(line);
    e.err  = (fail_beat < 4);
    e.data = last_data;
    e.lat  = lat;
    resp_q.push_back(e);
    bif.bus_addr_i  = 16'(line);
    bif.bus_data_i  = wl;
    bif.bus_we_i    = we;
    bif.bus_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    if (scramble) begin
      bif.bus_addr_i = 16'($urandom);
      bif.bus_data_i = {$urandom, $urandom, $urandom, $urandom};
      bif.bus_we_i   = ~we;
    end
    wait_resp();
    bif.bus_valid_i = 1'b0;
    if (fail_beat < 4) beat_q.delete();
  endtask

  initial begin
    logic [127:0] t1_line;
    logic [127:0] t2_line;
    int k;
    bif.bus_addr_i  = '0;
    bif.bus_data_i  = '0;
    bif.bus_we_i    = 1'b0;
    bif.bus_valid_i = 1'b0;
    for (int w = 0; w < 256; w++) begin
      ref_mem[w]   = $urandom;
      mem_store[w] = ref_mem[w];
    end
    gap = '{0, 0, 0, 0};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(bif.busy_o), 128'(0));
    chk("rst_req", 128'(bif.mem_req_o), 128'(0));
    chk("rst_valid", 128'({bif.bus_valid_o, bif.bus_err_o, bif.mem_we_o}), 128'(0));
    chk("rst_data", bif.bus_data_o, 128'(0));
    chk("rst_mem_addr", 128'(bif.mem_addr_o), 128'(0));
    rst = 1'b0;
    spur_en = 1'b1;

    // T1: read line 0x010 with ack every cycle.
    t1_line = {32'hA3A3_0003, 32'hA2A2_0002, 32'hA1A1_0001, 32'hA0A0_0000};
    for (int i = 0; i < 4; i++) begin
      ref_mem[16'h40 + i]   = t1_line[i*32 +: 32];
      mem_store[16'h40 + i] = t1_line[i*32 +: 32];
    end
    do_tx(16'h010, 1'b0, '0, 0, 0, 0, 0, 1'b0);
    chk("t1_line", bif.bus_data_o, t1_line);

    // T2: write line 0x020, ack every third cycle, then read it back.
    t2_line = {32'hD3D3_3333, 32'hD2D2_2222, 32'hD1D1_1111, 32'hD0D0_0000};
    do_tx(16'h020, 1'b1, t2_line, 2, 2, 2, 2, 1'b0);
    chk("t2_hold", bif.bus_data_o, t1_line);
    do_tx(16'h020, 1'b0, '0, 1, 0, 3, 0, 1'b1);
    chk("t2_readback", bif.bus_data_o, t2_line);

    // Watchdog boundary: four idle cycles per beat still completes.
    do_tx(3, 1'b0, '0, 4, 4, 4, 4, 1'b0);

    // T3: no ack ever -> error pulse five cycles after req rises.
    do_tx(5, 1'b0, '0, NEVER, 0, 0, 0, 1'b0);
    chk("t3_data_zero", bif.bus_data_o, 128'(0));
    wait_idle();
    chk("t3_idle", 128'(bif.busy_o), 128'(0));

    // Write that hangs on beat 2: beats 0/1 land, error reported.
    do_tx(6, 1'b1, {$urandom, $urandom, $urandom, $urandom}, 0, 1, NEVER, 0, 1'b0);
    do_tx(6, 1'b0, '0, 0, 0, 0, 0, 1'b0);

    // T4: valid held through GAP is ignored; held one more cycle restarts.
    wait_idle();
    gap = '{0, 0, 0, 0};
    mbeat = 0;
    mwait = 0;
    for (int r = 0; r < 2; r++) begin
      resp_t e;
      for (int i = 0; i < 4; i++) begin
        beat_t b;
        b.addr  = 18'(7 * 4 + i);
        b.we    = 1'b0;
        b.wdata = '0;
        beat_q.push_back(b);
      end
      last_data = ref_line(7);
      e.err  = 1'b0;
      e.data = last_data;
      e.lat  = 4;
      resp_q.push_back(e);
    end
    bif.bus_addr_i  = 16'd7;
    bif.bus_we_i    = 1'b0;
    bif.bus_valid_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    k = cyc;
    for (int n = 0; n < 12; n++) begin
      if (cyc - k == 4) chk("t4_req_resp", 128'(bif.mem_req_o), 128'(0));
      if (cyc - k == 5) begin
        chk("t4_req_gap", 128'(bif.mem_req_o), 128'(0));
        acc_cyc = k + 7;
        mbeat = 0;
        mwait = 0;
      end
      if (cyc - k == 6) chk("t4_req_idle", 128'(bif.mem_req_o), 128'(0));
      if (cyc - k == 7) begin
        chk("t4_req_restart", 128'(bif.mem_req_o), 128'(1));
        break;
      end
      @(negedge clk);
    end
    bif.bus_valid_i = 1'b0;
    wait_resp();

    // T5: reset during beat 2 of a read abandons it silently.
    wait_idle();
    gap = '{0, 0, 0, 0};
    mbeat = 0;
    mwait = 0;
    for (int i = 0; i < 4; i++) begin
      beat_t b;
      b.addr  = 18'(9 * 4 + i);
      b.we    = 1'b0;
      b.wdata = '0;
      beat_q.push_back(b);
    end
    bif.bus_addr_i  = 16'd9;
    bif.bus_we_i    = 1'b0;
    bif.bus_valid_i = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      #1;
      if (mbeat >= 3) break;
    end
    bif.bus_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_req", 128'(bif.mem_req_o), 128'(0));
    chk("t5_busy", 128'(bif.busy_o), 128'(0));
    chk("t5_data", bif.bus_data_o, 128'(0));
    rst = 1'b0;
    beat_q.delete();
    last_data = '0;
    repeat (3) @(negedge clk);
    do_tx(9, 1'b0, '0, 0, 0, 0, 0, 1'b0);

    // Randomized traffic with scrambled bus inputs and occasional hung beats.
    for (int t = 0; t < 40; t++) begin
      int g[4];
      for (int i = 0; i < 4; i++) g[i] = int'($urandom % (TO + 1));
      if ($urandom % 8 == 0) g[$urandom % 4] = NEVER;
      do_tx(int'($urandom % 64), 1'($urandom % 2),
            {$urandom, $urandom, $urandom, $urandom},
            g[0], g[1], g[2], g[3], 1'($urandom % 2));
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk("resp_queue_empty", 128'(resp_q.size()), 128'(0));
    chk("beat_queue_empty", 128'(beat_q.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
